alu_bus_ctrl: RTL and testbench
===============================

Name: alu_bus_ctrl

Overview:
Bus-slave controller that sits between the system BUS and the combinational 32-bit ALU. It is the driving end of the ALU's a/b/op/ALU_result interface. Software writes operands and an opcode, then issues a start. The block drives the ALU, waits a programmable settle time, captures the result, and reports done/error status for readback. It replaces ad-hoc operand driving with a register-mapped, sequenced engine.

Parameters:
ADDR_W, 8, BUS address width; only addr[2:0] is decoded.
DATA_W, 32, operand, result and bus data width.
EXEC_CYCLES, 2, cycles the ALU inputs are held stable before capture (legal range 1..15).

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
s_sel  input  1  slave select from the BUS.
s_wr  input  1  1 = write, 0 = read; valid when s_sel=1.
s_addr  input  ADDR_W  register offset.
s_din  input  DATA_W  write data.
s_dout  output  DATA_W  read data, registered.
alu_a  output  DATA_W  operand A to the ALU.
alu_b  output  DATA_W  operand B to the ALU.
alu_op  output  4  opcode to the ALU.
alu_result  input  DATA_W  ALU result, combinational from alu_a/alu_b/alu_op.

Behaviour:
- Register map (addr[2:0]):
  - 0 OPA (RW)
  - 1 OPB (RW)
  - 2 OPCODE (RW, bits[3:0], upper bits read 0)
  - 3 CTRL (WO: bit0 start, bit1 clear_done; reads 0)
  - 4 STATUS (RO: bit0 busy, bit1 done, bit2 op_err)
  - 5 RESULT (RO)
  - 6-7 read 0, writes ignored.
- Legal opcodes: 0000 NOP (result 0), 0001 NOT A, 0010 AND, 0011 OR, 0100 XOR, 0101 XNOR, 0110 ADD (mod 2^32, carry dropped), 0111 SUB (A-B mod 2^32). Opcodes 1000-1111 are illegal.
- Reset (async, reset_n=0): all registers, s_dout, alu_a, alu_b, alu_op = 0; FSM = IDLE; busy/done/op_err = 0.
- Read path: s_dout <= selected register one cycle after s_sel=1 & s_wr=0. Otherwise s_dout <= 0.
- FSM states: IDLE, EXEC, CAPTURE, DONE.
  - IDLE: a write of CTRL.bit0=1 latches OPA/OPB/OPCODE onto alu_a/alu_b/alu_op.
    - Opcode legal: go to EXEC, busy=1, load cnt=EXEC_CYCLES-1.
    - Opcode illegal: alu_op=0000, RESULT=0, op_err=1, done=1, go directly to DONE (busy stays 0).
  - EXEC: cnt decrements each cycle; at cnt==0 go to CAPTURE.
  - CAPTURE: RESULT <= alu_result, done=1, busy=0, go to DONE.
  - Latency: start write at cycle N, done visible at cycle N+EXEC_CYCLES+1.
  - DONE: holds. CTRL.bit1=1 clears done and op_err and returns to IDLE. CTRL.bit0=1 behaves as a new start from IDLE (done and op_err cleared first).
  - If bit0 and bit1 are written together, start wins.
- While busy: writes to OPA/OPB/OPCODE/CTRL are ignored; reads are allowed. alu_a/alu_b/alu_op stay stable throughout EXEC and CAPTURE.
- RESULT holds its last value until the next CAPTURE or illegal-op start.
- reset_n asserted mid-EXEC aborts immediately to reset values; no partial capture.

Optional Feature:
ALU_BUS_CTRL_IRQ_EN
- Defined:
  - Adds output port o_irq (1 bit) and register offset 6 IRQ_EN (RW, bit0).
  - o_irq is registered, equals done & IRQ_EN.bit0, clears with done, reset 0.
- Undefined: no o_irq port; offset 6 reads 0.

Test Plan:
- Reset, then read STATUS and RESULT -> both 0x00000000; alu_a/alu_b/alu_op = 0.
- OPA=0xFFFFFFFF, OPB=0x0000000F, OPCODE=0110, start -> busy=1 for EXEC_CYCLES+1 cycles; RESULT=0x0000000E, STATUS=0x2.
- OPA=5, OPB=7, OPCODE=0111, start -> RESULT=0xFFFFFFFE. Then OPA=3, OPCODE=0001, start from DONE -> RESULT=0xFFFFFFFC.
- OPA=0x5, OPB=0x9, OPCODE=0010, start; write OPA=0xA during EXEC -> RESULT=0x1, OPA still reads 0x5.
- OPCODE=1000, start -> STATUS=0x6, RESULT=0, alu_op=0000. Write CTRL=0x2 -> STATUS=0x0.
- Start ADD, assert reset_n low during EXEC -> all outputs 0, STATUS=0 after release, no stale RESULT.

Source files
------------

// File: rtl/alu_bus_ctrl.sv
// alu_bus_ctrl: bus-mapped sequencer that drives a combinational ALU, waits EXEC_CYCLES, captures the result.
// Ports: clk, reset_n (async low); bus s_sel/s_wr/s_addr/s_din -> s_dout (registered);
// ALU side alu_a/alu_b/alu_op out, alu_result in. Optional macro ALU_BUS_CTRL_IRQ_EN adds o_irq + IRQ_EN at offset 6.
module alu_bus_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result
`ifdef ALU_BUS_CTRL_IRQ_EN
  ,
  output logic              o_irq
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, a_q, a_d, b_q, b_d, dout_q, dout_d, rdata;
  logic [3:0] opc_q, opc_d, op_q, op_d, cnt_q, cnt_d;
  logic done_q, done_d, err_q, err_d, busy, wr, start, clr, irq_bit;
  logic [2:0] a;
  logic unused_addr;
  assign unused_addr = ^s_addr[ADDR_W-1:3];
  assign a     = s_addr[2:0];
  assign busy  = (state_q == EXEC) || (state_q == CAPTURE);
  // Bus writes to operands and CTRL are dropped while a computation is in flight.
  assign wr    = s_sel && s_wr && !busy;
  assign start = wr && a == 3'd3 && s_din[0];
  assign clr   = wr && a == 3'd3 && s_din[1];
`ifdef ALU_BUS_CTRL_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
  assign irq_en_d = (s_sel && s_wr && a == 3'd6) ? s_din[0] : irq_en_q;
  assign irq_bit  = irq_en_q;
  assign o_irq    = irq_q;
`else
  assign irq_bit  = 1'b0;
`endif
  always_comb begin
    rdata = a == 3'd0 ? opa_q :
            a == 3'd1 ? opb_q :
            a == 3'd2 ? DATA_W'(opc_q) :
            a == 3'd4 ? DATA_W'({err_q, done_q, busy}) :
            a == 3'd5 ? res_q :
            a == 3'd6 ? DATA_W'(irq_bit) : '0;
    dout_d = (s_sel && !s_wr) ? rdata : '0;
    opa_d = (wr && a == 3'd0) ? s_din : opa_q;
    opb_d = (wr && a == 3'd1) ? s_din : opb_q;
    opc_d = (wr && a == 3'd2) ? s_din[3:0] : opc_q;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = done_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d    = opa_q;
          b_d    = opb_q;
          // Opcodes with bit3 set are illegal: finish immediately with an error and a zero result.
          op_d   = opc_q[3] ? 4'd0 : opc_q;
          res_d  = opc_q[3] ? '0 : res_q;
          err_d  = opc_q[3];
          done_d = opc_q[3];
          cnt_d  = 4'(EXEC_CYCLES - 1);
          state_d = opc_q[3] ? DONE : EXEC;
        end else if (clr) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      EXEC: begin
        cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? CAPTURE : EXEC;
      end
      default: begin
        res_d   = alu_result;
        done_d  = 1'b1;
        state_d = DONE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
    end
  end
`ifdef ALU_BUS_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_d & irq_en_d;
    end
  end
`endif
  assign s_dout = dout_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
endmodule

// File: tb/tb_alu_bus_ctrl.sv
// tb_alu_bus_ctrl: directed vector table plus hand sequences for alu_bus_ctrl with a behavioural ALU attached.
module tb_alu_bus_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, s_sel = 1'b0, s_wr = 1'b0;
  logic [7:0] s_addr = '0;
  logic [31:0] s_din = '0, s_dout, alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  int pass_cnt = 0, total = 0;
`ifdef ALU_BUS_CTRL_IRQ_EN
  logic o_irq;
`endif
  always #5 clk = ~clk;
  alu_bus_ctrl dut (
    .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
    .s_dout(s_dout), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
`ifdef ALU_BUS_CTRL_IRQ_EN
    , .o_irq(o_irq)
`endif
  );
  always_comb
    alu_result = alu_op == 4'd1 ? ~alu_a :
                 alu_op == 4'd2 ? alu_a & alu_b :
                 alu_op == 4'd3 ? alu_a | alu_b :
                 alu_op == 4'd4 ? alu_a ^ alu_b :
                 alu_op == 4'd5 ? ~(alu_a ^ alu_b) :
                 alu_op == 4'd6 ? alu_a + alu_b :
                 alu_op == 4'd7 ? alu_a - alu_b : 32'd0;
  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [31:0] res, st;
    logic [3:0]  aop;
  } vec_t;
  vec_t v[11];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = {5'd0, a}; s_din = d;
    @(negedge clk);
    s_sel = 1'b0; s_wr = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = {5'd0, a};
    @(negedge clk);
    s_sel = 1'b0;
    d = s_dout;
  endtask
  task automatic wait_done(input string name);
    logic [31:0] st;
    int n = 0;
    do begin
      rd(3'd4, st);
      n++;
    end while (st[0] && n < 20);
    check({name, " idle"}, {31'd0, st[0]}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] r;
    logic [31:0] rec[8];
    int busy_cnt;
    v[0]  = '{32'hFFFFFFFF, 32'h0000000F, 4'h6, 32'h0000000E, 32'h2, 4'h6};
    v[1]  = '{32'h00000005, 32'h00000007, 4'h7, 32'hFFFFFFFE, 32'h2, 4'h7};
    v[2]  = '{32'h00000003, 32'h00000000, 4'h1, 32'hFFFFFFFC, 32'h2, 4'h1};
    v[3]  = '{32'h00000005, 32'h00000009, 4'h2, 32'h00000001, 32'h2, 4'h2};
    v[4]  = '{32'hF0F00000, 32'h00000F0F, 4'h3, 32'hF0F00F0F, 32'h2, 4'h3};
    v[5]  = '{32'hFF00FF00, 32'h0F0F0F0F, 4'h4, 32'hF00FF00F, 32'h2, 4'h4};
    v[6]  = '{32'h12345678, 32'h12345678, 4'h5, 32'hFFFFFFFF, 32'h2, 4'h5};
    v[7]  = '{32'hAAAAAAAA, 32'h55555555, 4'h0, 32'h00000000, 32'h2, 4'h0};
    v[8]  = '{32'h00000001, 32'h00000001, 4'h6, 32'h00000002, 32'h2, 4'h6};
    v[9]  = '{32'h00000001, 32'h00000001, 4'h8, 32'h00000000, 32'h6, 4'h0};
    v[10] = '{32'h00000001, 32'h00000001, 4'hF, 32'h00000000, 32'h6, 4'h0};
    repeat (3) @(negedge clk);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst alu_op", {28'd0, alu_op}, 32'd0);
    check("rst s_dout", s_dout, 32'd0);
    reset_n = 1'b1;
    rd(3'd4, r); check("rst status", r, 32'd0);
    rd(3'd5, r); check("rst result", r, 32'd0);
    for (int i = 0; i < 11; i++) begin
      wr(3'd0, v[i].a); wr(3'd1, v[i].b); wr(3'd2, {28'd0, v[i].op}); wr(3'd3, 32'd1);
      wait_done($sformatf("vec%0d", i));
      rd(3'd5, r); check($sformatf("vec%0d result", i), r, v[i].res);
      rd(3'd4, r); check($sformatf("vec%0d status", i), r, v[i].st);
      check($sformatf("vec%0d alu_op", i), {28'd0, alu_op}, {28'd0, v[i].aop});
      wr(3'd3, 32'd2);
      rd(3'd4, r); check($sformatf("vec%0d cleared", i), r, 32'd0);
    end
    wr(3'd0, 32'hFFFFFFFF); wr(3'd1, 32'h0000000F); wr(3'd2, 32'd6);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = 8'd3; s_din = 32'd1;
    @(negedge clk);
    s_wr = 1'b0; s_addr = 8'd4;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rec[i] = s_dout;
      if (s_dout[0]) busy_cnt++;
    end
    s_sel = 1'b0;
    check("busy cycles", busy_cnt, 32'd3);
    check("done latency", rec[3], 32'd2);
    check("busy pre-done", rec[2], 32'd1);
    rd(3'd5, r); check("add result", r, 32'h0000000E);
    wr(3'd0, 32'd5); wr(3'd1, 32'd7); wr(3'd2, 32'd7); wr(3'd3, 32'd1);
    wait_done("sub");
    rd(3'd5, r); check("sub result", r, 32'hFFFFFFFE);
    wr(3'd0, 32'd3); wr(3'd2, 32'd1); wr(3'd3, 32'd1);
    wait_done("restart");
    rd(3'd5, r); check("restart result", r, 32'hFFFFFFFC);
    rd(3'd4, r); check("restart status", r, 32'h2);
    wr(3'd3, 32'd2);
    wr(3'd0, 32'd5); wr(3'd1, 32'd9); wr(3'd2, 32'd2); wr(3'd3, 32'd1);
    wr(3'd0, 32'hA);
    check("exec alu_a", alu_a, 32'd5);
    wait_done("and");
    rd(3'd5, r); check("and result", r, 32'h1);
    rd(3'd0, r); check("opa kept", r, 32'h5);
    wr(3'd2, 32'd8); wr(3'd3, 32'd1);
    check("illegal alu_op", {28'd0, alu_op}, 32'd0);
    rd(3'd4, r); check("illegal status", r, 32'h6);
    rd(3'd5, r); check("illegal result", r, 32'd0);
    wr(3'd3, 32'd2);
    rd(3'd4, r); check("illegal cleared", r, 32'd0);
    wr(3'd0, 32'd2); wr(3'd1, 32'd3); wr(3'd2, 32'd6); wr(3'd3, 32'd1);
    wait_done("pre both");
    wr(3'd3, 32'd3);
    rd(3'd4, r); check("start wins", r, 32'h1);
    wait_done("both");
    rd(3'd5, r); check("both result", r, 32'd5);
    wr(3'd2, 32'hFFFFFFF7);
    rd(3'd2, r); check("opcode mask", r, 32'h7);
    rd(3'd3, r); check("ctrl reads 0", r, 32'd0);
    rd(3'd7, r); check("addr7 reads 0", r, 32'd0);
`ifdef ALU_BUS_CTRL_IRQ_EN
    wr(3'd6, 32'd1);
    rd(3'd6, r); check("irq_en", r, 32'd1);
    wr(3'd3, 32'd1);
    wait_done("irq");
    @(negedge clk);
    check("irq set", {31'd0, o_irq}, 32'd1);
    wr(3'd3, 32'd2);
    @(negedge clk);
    check("irq clr", {31'd0, o_irq}, 32'd0);
`else
    rd(3'd6, r); check("addr6 reads 0", r, 32'd0);
`endif
    wr(3'd0, 32'd1); wr(3'd1, 32'd1); wr(3'd2, 32'd6); wr(3'd3, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort alu_a", alu_a, 32'd0);
    check("abort alu_b", alu_b, 32'd0);
    check("abort alu_op", {28'd0, alu_op}, 32'd0);
    check("abort s_dout", s_dout, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(3'd4, r); check("abort status", r, 32'd0);
    repeat (5) @(negedge clk);
    rd(3'd5, r); check("abort result", r, 32'd0);
    rd(3'd4, r); check("abort idle", r, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
